// File: rtl/osu_target_pool.sv
// osu_target_pool: pool of NUM_TARGETS on-screen hit targets with LFSR placement,
// tick-driven aging, oldest-match key resolution and saturating hit/miss totals.
`default_nettype none

module osu_target_pool #(
  parameter int          NUM_TARGETS = 4,
  parameter int          X_WIDTH     = 9,
  parameter int          Y_WIDTH     = 8,
  parameter int          X_MAX       = 304,
  parameter int          Y_MAX       = 214,
  parameter int          LIFETIME    = 60,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   spawn_req,
  input  logic                   key_valid,
  input  logic [7:0]             key_code,
  input  logic [2:0]             rd_idx,
  output logic                   spawn_ack,
  output logic                   spawn_full,
  output logic [2:0]             spawn_slot,
  output logic                   hit_pulse,
  output logic [2:0]             hit_slot,
  output logic                   wrong_pulse,
  output logic [NUM_TARGETS-1:0] miss_mask,
  output logic [15:0]            hit_count,
  output logic [15:0]            miss_count,
  output logic                   rd_active,
  output logic [X_WIDTH-1:0]     rd_x,
  output logic [Y_WIDTH-1:0]     rd_y,
  output logic [1:0]             rd_key,
  output logic [7:0]             rd_life
);

  localparam logic [X_WIDTH-1:0] X_MAX_V  = X_WIDTH'(X_MAX);
  localparam logic [X_WIDTH-1:0] X_SPAN_V = X_WIDTH'(X_MAX + 1);
  localparam logic [Y_WIDTH-1:0] Y_MAX_V  = Y_WIDTH'(Y_MAX);
  localparam logic [Y_WIDTH-1:0] Y_SPAN_V = Y_WIDTH'(Y_MAX + 1);
  localparam logic [7:0]         LIFE_V   = 8'(LIFETIME);

  logic [15:0]            lfsr_q, lfsr_d;
  logic [NUM_TARGETS-1:0] active_q, active_d;
  logic [X_WIDTH-1:0]     x_q    [NUM_TARGETS];
  logic [X_WIDTH-1:0]     x_d    [NUM_TARGETS];
  logic [Y_WIDTH-1:0]     y_q    [NUM_TARGETS];
  logic [Y_WIDTH-1:0]     y_d    [NUM_TARGETS];
  logic [1:0]             key_q  [NUM_TARGETS];
  logic [1:0]             key_d  [NUM_TARGETS];
  logic [7:0]             life_q [NUM_TARGETS];
  logic [7:0]             life_d [NUM_TARGETS];

  logic                   spawn_ack_q, spawn_ack_d;
  logic                   spawn_full_q, spawn_full_d;
  logic [2:0]             spawn_slot_q, spawn_slot_d;
  logic                   hit_pulse_q, hit_pulse_d;
  logic [2:0]             hit_slot_q, hit_slot_d;
  logic                   wrong_pulse_q, wrong_pulse_d;
  logic [NUM_TARGETS-1:0] miss_mask_q, miss_mask_d;
  logic [15:0]            hit_count_q, hit_count_d;
  logic [15:0]            miss_count_q, miss_count_d;

  logic                   key_known;
  logic [1:0]             key_id;
  logic                   hit_found;
  logic [2:0]             hit_idx;
  logic [7:0]             hit_life;
  logic                   free_found;
  logic [2:0]             free_idx;
  logic [X_WIDTH-1:0]     raw_x, spawn_x;
  logic [Y_WIDTH-1:0]     raw_y, spawn_y;
  logic [1:0]             spawn_key;
  logic [3:0]             miss_n;
  logic [16:0]            miss_sum;

  always_comb begin
    key_known = 1'b1;
    key_id    = 2'd0;
    case (key_code)
      8'h1C:   key_id = 2'd0;
      8'h1B:   key_id = 2'd1;
      8'h23:   key_id = 2'd2;
      8'h2B:   key_id = 2'd3;
      default: key_known = 1'b0;
    endcase
  end

  // Oldest matching target wins; strict '<' keeps the lowest index on a life tie.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = 3'd0;
    hit_life  = 8'hFF;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (key_valid && key_known && active_q[i] && (key_q[i] == key_id) &&
          (!hit_found || (life_q[i] < hit_life))) begin
        hit_found = 1'b1;
        hit_idx   = 3'(i);
        hit_life  = life_q[i];
      end
    end
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = 3'd0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (!active_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = 3'(i);
      end
    end
  end

  // Raw LFSR fields span less than twice the legal range, so one subtraction folds them in.
  always_comb begin
    raw_x     = lfsr_q[X_WIDTH-1:0];
    raw_y     = lfsr_q[15 -: Y_WIDTH];
    spawn_x   = (raw_x > X_MAX_V) ? (raw_x - X_SPAN_V) : raw_x;
    spawn_y   = (raw_y > Y_MAX_V) ? (raw_y - Y_SPAN_V) : raw_y;
    spawn_key = lfsr_q[1:0] ^ lfsr_q[9:8];
  end

  always_comb begin
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    active_d    = active_q;
    miss_mask_d = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      x_d[i]    = x_q[i];
      y_d[i]    = y_q[i];
      key_d[i]  = key_q[i];
      life_d[i] = life_q[i];
      if (hit_found && (hit_idx == 3'(i))) begin
        active_d[i] = 1'b0;
        life_d[i]   = 8'd0;
      end else if (tick && active_q[i]) begin
        if (life_q[i] == 8'd1) begin
          active_d[i]    = 1'b0;
          life_d[i]      = 8'd0;
          miss_mask_d[i] = 1'b1;
        end else begin
          life_d[i] = life_q[i] - 8'd1;
        end
      end
      // The chosen slot was inactive before the edge, so it never collides with a hit or expiry.
      if (spawn_req && free_found && (free_idx == 3'(i))) begin
        active_d[i] = 1'b1;
        x_d[i]      = spawn_x;
        y_d[i]      = spawn_y;
        key_d[i]    = spawn_key;
        life_d[i]   = LIFE_V;
      end
    end

    spawn_ack_d   = spawn_req && free_found;
    spawn_full_d  = spawn_req && !free_found;
    spawn_slot_d  = (spawn_req && free_found) ? free_idx : 3'd0;
    hit_pulse_d   = hit_found;
    hit_slot_d    = hit_found ? hit_idx : 3'd0;
    wrong_pulse_d = key_valid && !hit_found;

    hit_count_d = hit_count_q;
    if (hit_found && (hit_count_q != 16'hFFFF)) begin
      hit_count_d = hit_count_q + 16'd1;
    end

    miss_n = 4'd0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      miss_n = miss_n + {3'd0, miss_mask_d[i]};
    end
    miss_sum     = {1'b0, miss_count_q} + {13'd0, miss_n};
    miss_count_d = miss_sum[16] ? 16'hFFFF : miss_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q        <= SEED;
      active_q      <= '0;
      spawn_ack_q   <= 1'b0;
      spawn_full_q  <= 1'b0;
      spawn_slot_q  <= 3'd0;
      hit_pulse_q   <= 1'b0;
      hit_slot_q    <= 3'd0;
      wrong_pulse_q <= 1'b0;
      miss_mask_q   <= '0;
      hit_count_q   <= 16'd0;
      miss_count_q  <= 16'd0;
      for (int i = 0; i < NUM_TARGETS; i++) begin
        x_q[i]    <= '0;
        y_q[i]    <= '0;
        key_q[i]  <= 2'd0;
        life_q[i] <= 8'd0;
      end
    end else begin
      lfsr_q        <= lfsr_d;
      active_q      <= active_d;
      spawn_ack_q   <= spawn_ack_d;
      spawn_full_q  <= spawn_full_d;
      spawn_slot_q  <= spawn_slot_d;
      hit_pulse_q   <= hit_pulse_d;
      hit_slot_q    <= hit_slot_d;
      wrong_pulse_q <= wrong_pulse_d;
      miss_mask_q   <= miss_mask_d;
      hit_count_q   <= hit_count_d;
      miss_count_q  <= miss_count_d;
      for (int i = 0; i < NUM_TARGETS; i++) begin
        x_q[i]    <= x_d[i];
        y_q[i]    <= y_d[i];
        key_q[i]  <= key_d[i];
        life_q[i] <= life_d[i];
      end
    end
  end

  always_comb begin
    rd_active = 1'b0;
    rd_x      = '0;
    rd_y      = '0;
    rd_key    = 2'd0;
    rd_life   = 8'd0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (rd_idx == 3'(i)) begin
        rd_active = active_q[i];
        rd_x      = x_q[i];
        rd_y      = y_q[i];
        rd_key    = key_q[i];
        rd_life   = life_q[i];
      end
    end
  end

  assign spawn_ack   = spawn_ack_q;
  assign spawn_full  = spawn_full_q;
  assign spawn_slot  = spawn_slot_q;
  assign hit_pulse   = hit_pulse_q;
  assign hit_slot    = hit_slot_q;
  assign wrong_pulse = wrong_pulse_q;
  assign miss_mask   = miss_mask_q;
  assign hit_count   = hit_count_q;
  assign miss_count  = miss_count_q;

endmodule

`default_nettype wire

// File: tb/tb_osu_target_pool.sv
// tb_osu_target_pool: directed + random stimulus for osu_target_pool, checked against a
// slot-list reference model; a second LIFETIME=1 instance drives miss_count into saturation.
`default_nettype none

module tb_osu_target_pool;

  localparam int          NT   = 4;
  localparam int          XW   = 9;
  localparam int          YW   = 8;
  localparam int          XM   = 304;
  localparam int          YM   = 214;
  localparam int          LT   = 60;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk = 1'b0;
  logic          reset, tick, spawn_req, key_valid;
  logic [7:0]    key_code;
  logic [2:0]    rd_idx;
  logic          spawn_ack, spawn_full, hit_pulse, wrong_pulse, rd_active;
  logic [2:0]    spawn_slot, hit_slot;
  logic [NT-1:0] miss_mask;
  logic [15:0]   hit_count, miss_count;
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic [1:0]    rd_key;
  logic [7:0]    rd_life;

  logic          sat_reset;
  logic          sat_ack, sat_full, sat_hit, sat_wrong, sat_active;
  logic [2:0]    sat_sslot, sat_hslot;
  logic [1:0]    sat_mask, sat_key;
  logic [15:0]   sat_hits, sat_misses;
  logic [XW-1:0] sat_x;
  logic [YW-1:0] sat_y;
  logic [7:0]    sat_life;
  int            sat_edges;

  int tests = 0;
  int fails = 0;

  // Reference model: state of each slot as the DUT should hold it after the last edge.
  bit          m_act  [NT];
  int          m_x    [NT];
  int          m_y    [NT];
  int          m_key  [NT];
  int          m_life [NT];
  logic [15:0] m_lfsr;
  int          m_hits, m_misses;
  bit          e_ack, e_full, e_hit, e_wrong;
  int          e_sslot, e_hslot, e_mask;

  always #10 clk = ~clk;

  osu_target_pool #(
    .NUM_TARGETS(NT), .X_WIDTH(XW), .Y_WIDTH(YW), .X_MAX(XM), .Y_MAX(YM),
    .LIFETIME(LT), .SEED(SEED)
  ) u_dut (
    .clk(clk), .reset(reset), .tick(tick), .spawn_req(spawn_req),
    .key_valid(key_valid), .key_code(key_code), .rd_idx(rd_idx),
    .spawn_ack(spawn_ack), .spawn_full(spawn_full), .spawn_slot(spawn_slot),
    .hit_pulse(hit_pulse), .hit_slot(hit_slot), .wrong_pulse(wrong_pulse),
    .miss_mask(miss_mask), .hit_count(hit_count), .miss_count(miss_count),
    .rd_active(rd_active), .rd_x(rd_x), .rd_y(rd_y), .rd_key(rd_key), .rd_life(rd_life)
  );

  osu_target_pool #(
    .NUM_TARGETS(2), .X_WIDTH(XW), .Y_WIDTH(YW), .X_MAX(XM), .Y_MAX(YM),
    .LIFETIME(1), .SEED(SEED)
  ) u_sat (
    .clk(clk), .reset(sat_reset), .tick(1'b1), .spawn_req(1'b1),
    .key_valid(1'b0), .key_code(8'h00), .rd_idx(3'd0),
    .spawn_ack(sat_ack), .spawn_full(sat_full), .spawn_slot(sat_sslot),
    .hit_pulse(sat_hit), .hit_slot(sat_hslot), .wrong_pulse(sat_wrong),
    .miss_mask(sat_mask), .hit_count(sat_hits), .miss_count(sat_misses),
    .rd_active(sat_active), .rd_x(sat_x), .rd_y(sat_y), .rd_key(sat_key), .rd_life(sat_life)
  );

  always @(posedge clk) begin
    if (sat_reset) sat_edges <= 0;
    else           sat_edges <= sat_edges + 1;
  end

  function automatic int code_to_id(logic [7:0] c);
    case (c)
      8'h1C:   return 0;
      8'h1B:   return 1;
      8'h23:   return 2;
      8'h2B:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [7:0] id_to_code(int id);
    case (id)
      0:       return 8'h1C;
      1:       return 8'h1B;
      2:       return 8'h23;
      default: return 8'h2B;
    endcase
  endfunction

  function automatic int pred_key(logic [15:0] l);
    return (int'(l) & 3) ^ ((int'(l) >> 8) & 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive strobes, advance the model, then compare every output and slot.
  task automatic step(input bit rs, input bit sp, input bit tk, input bit kv, input logic [7:0] kc);
    int kid, hi, fr, nexp, lv;
    @(negedge clk);
    reset = rs; spawn_req = sp; tick = tk; key_valid = kv; key_code = kc;
    if (rs) begin
      for (int i = 0; i < NT; i++) begin
        m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_key[i] = 0; m_life[i] = 0;
      end
      m_lfsr = SEED; m_hits = 0; m_misses = 0;
      e_ack = 0; e_full = 0; e_hit = 0; e_wrong = 0; e_sslot = 0; e_hslot = 0; e_mask = 0;
    end else begin
      kid = kv ? code_to_id(kc) : -1;
      hi = -1;
      if (kid >= 0)
        for (int i = 0; i < NT; i++)
          if (m_act[i] && m_key[i] == kid && (hi < 0 || m_life[i] < m_life[hi])) hi = i;
      fr = -1;
      for (int i = 0; i < NT; i++) if (!m_act[i] && fr < 0) fr = i;
      e_hit = (hi >= 0);   e_hslot = e_hit ? hi : 0;  e_wrong = kv && !e_hit;
      e_ack = sp && fr >= 0; e_full = sp && fr < 0;  e_sslot = e_ack ? fr : 0;
      e_mask = 0;
      for (int i = 0; i < NT; i++) begin
        if (m_act[i] && i != hi && tk) begin
          if (m_life[i] == 1) begin e_mask |= (1 << i); m_act[i] = 0; end
          else m_life[i]--;
        end
      end
      if (e_hit) m_act[hi] = 0;
      if (e_ack) begin
        lv = int'(m_lfsr);
        m_act[fr]  = 1;
        m_x[fr]    = (lv % (1 << XW)) % (XM + 1);
        m_y[fr]    = (lv >> (16 - YW)) % (YM + 1);
        m_key[fr]  = pred_key(m_lfsr);
        m_life[fr] = LT;
      end
      if (e_hit) m_hits = (m_hits < 65535) ? m_hits + 1 : 65535;
      nexp = $countones(e_mask);
      m_misses = (m_misses + nexp > 65535) ? 65535 : m_misses + nexp;
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
    @(posedge clk);
    #1;
    chk("spawn_ack", spawn_ack, e_ack);
    chk("spawn_full", spawn_full, e_full);
    chk("spawn_slot", spawn_slot, e_sslot);
    chk("hit_pulse", hit_pulse, e_hit);
    chk("hit_slot", hit_slot, e_hslot);
    chk("wrong_pulse", wrong_pulse, e_wrong);
    chk("miss_mask", miss_mask, e_mask);
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_misses);
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i);
      #1;
      if (i < NT) begin
        chk("rd_active", rd_active, m_act[i]);
        if (m_act[i]) begin
          chk("rd_x", rd_x, m_x[i]);
          chk("rd_y", rd_y, m_y[i]);
          chk("rd_key", rd_key, m_key[i]);
          chk("rd_life", rd_life, m_life[i]);
          chk("rd_x_bound", rd_x <= XM, 1);
          chk("rd_y_bound", rd_y <= YM, 1);
        end
      end else begin
        chk("rd_oob", {rd_active, rd_x, rd_y, rd_key, rd_life}, 0);
      end
    end
  endtask

  initial begin
    int k0, g, unused_id;
    bit found, r_sp, r_tk, r_kv;
    logic [7:0] r_kc;
    reset = 1'b1; sat_reset = 1'b1; tick = 0; spawn_req = 0; key_valid = 0;
    key_code = 8'h00; rd_idx = 3'd0;

    step(1, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00);
    sat_reset = 1'b0;
    chk("reset_hit_count", hit_count, 0);
    chk("reset_miss_count", miss_count, 0);

    // Fill the pool, then one more request must be refused.
    for (int k = 0; k < NT + 1; k++) begin
      step(0, 1, 0, 0, 8'h00);
      chk("fill_ack", spawn_ack, k < NT);
      chk("fill_full", spawn_full, k >= NT);
      if (k < NT) chk("fill_slot", spawn_slot, k);
    end

    // Single target expires on its LIFETIME-th tick.
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    for (int t = 0; t < LT; t++) step(0, 0, 1, 0, 8'h00);
    chk("expire_mask", miss_mask, 4'b0001);
    chk("expire_count", miss_count, 1);
    chk("expire_no_hit", hit_pulse, 0);

    // Two targets with the same key: the older one is hit first.
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    k0 = m_key[0];
    for (int t = 0; t < 5; t++) step(0, 0, 1, 0, 8'h00);
    found = 0;
    for (g = 0; g < 400 && !found; g++) begin
      if (pred_key(m_lfsr) == k0) found = 1;
      else step(0, 0, 0, 0, 8'h00);
    end
    chk("samekey_search", found, 1);
    step(0, 1, 0, 0, 8'h00);
    chk("samekey_slot1_key", m_key[1], k0);
    step(0, 0, 0, 1, id_to_code(k0));
    chk("oldest_hit", hit_pulse, 1);
    chk("oldest_slot", hit_slot, 0);
    chk("oldest_count", hit_count, 1);
    step(0, 0, 0, 1, id_to_code(k0));
    chk("second_slot", hit_slot, 1);
    chk("second_count", hit_count, 2);

    // Wrong keys with a full pool.
    step(1, 0, 0, 0, 8'h00);
    for (int k = 0; k < NT; k++) step(0, 1, 0, 0, 8'h00);
    step(0, 0, 0, 1, 8'h29);
    chk("space_wrong", wrong_pulse, 1);
    chk("space_no_hit", hit_pulse, 0);
    chk("space_hits", hit_count, 0);
    unused_id = -1;
    for (int id = 0; id < 4; id++) begin
      found = 0;
      for (int i = 0; i < NT; i++) if (m_key[i] == id) found = 1;
      if (!found && unused_id < 0) unused_id = id;
    end
    if (unused_id >= 0) begin
      step(0, 0, 0, 1, id_to_code(unused_id));
      chk("unmatched_wrong", wrong_pulse, 1);
      chk("unmatched_hits", hit_count, 0);
    end
    step(0, 0, 0, 0, 8'h1C);
    chk("no_valid_no_wrong", wrong_pulse, 0);

    // Hit beats expiry on the same slot.
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    for (int t = 0; t < LT - 1; t++) step(0, 0, 1, 0, 8'h00);
    chk("life_one", m_life[0], 1);
    step(0, 0, 1, 1, id_to_code(m_key[0]));
    chk("hitwins_hit", hit_pulse, 1);
    chk("hitwins_mask", miss_mask, 0);
    chk("hitwins_misses", miss_count, 0);

    // Full pool expiring while a spawn arrives: freed slots become usable one cycle later.
    step(1, 0, 0, 0, 8'h00);
    for (int k = 0; k < NT; k++) step(0, 1, 0, 0, 8'h00);
    for (int t = 0; t < LT - 1; t++) step(0, 0, 1, 0, 8'h00);
    step(0, 1, 1, 0, 8'h00);
    chk("expire_spawn_full", spawn_full, 1);
    chk("expire_spawn_mask", miss_mask, 4'b1111);
    chk("expire_spawn_misses", miss_count, 4);
    step(0, 1, 0, 0, 8'h00);
    chk("reuse_ack", spawn_ack, 1);
    chk("reuse_slot", spawn_slot, 0);

    // Random mix of spawns, ticks and key presses.
    for (int n = 0; n < 600; n++) begin
      r_sp = ($urandom_range(0, 99) < 35);
      r_tk = ($urandom_range(0, 99) < 30);
      r_kv = ($urandom_range(0, 99) < 40);
      g    = int'($urandom_range(0, 4));
      r_kc = (g == 4) ? 8'h29 : id_to_code(g);
      step(0, r_sp, r_tk, r_kv, r_kc);
    end

    // Reset mid-game drops everything without reporting misses.
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 8'h00);
    step(1, 0, 1, 0, 8'h00);
    chk("midreset_mask", miss_mask, 0);
    chk("midreset_hits", hit_count, 0);
    chk("midreset_misses", miss_count, 0);

    // Saturation on the LIFETIME=1 instance: one expiry per cycle after the first spawn.
    chk("sat_running", sat_misses, (sat_edges - 1 > 65535) ? 65535 : sat_edges - 1);
    g = 0;
    while (sat_edges < 65540 && g < 70000) begin
      @(posedge clk);
      g++;
    end
    #1;
    chk("sat_reached", sat_misses, 16'hFFFF);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("sat_hold", sat_misses, 16'hFFFF);
      chk("sat_mask_active", sat_mask != 2'b00, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
